// File: rtl/dout_sched_pkg.sv
// Shared types and default sizing for the digital-output sequence scheduler.
package dout_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SAFE = 2'd2
    } sched_state_e;

    localparam int DEF_N_CH  = 16;
    localparam int DEF_DLY_W = 16;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/dout_cmd_fifo.sv
// Synchronous command FIFO holding packed {value, mask, delay} entries.
module dout_cmd_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dout_seq_scheduler.sv
// Queues masked output-update commands and applies each after its own delay,
// with flush and a safe-state override.
module dout_seq_scheduler
    import dout_sched_pkg::*;
#(
    parameter int              N_CH     = DEF_N_CH,
    parameter int              DLY_W    = DEF_DLY_W,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [N_CH-1:0] SAFE_VAL = '0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [N_CH-1:0]        cmd_value,
    input  logic [N_CH-1:0]        cmd_mask,
    input  logic [DLY_W-1:0]       cmd_delay,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   safe_req,
    output logic [N_CH-1:0]        dout,
    output logic                   applied,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CMD_W = 2 * N_CH + DLY_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    sched_state_e      state, state_nxt;
    logic [CMD_W-1:0]  head;
    logic [N_CH-1:0]   head_value, head_mask;
    logic [DLY_W-1:0]  head_delay;
    logic [N_CH-1:0]   cur_value, cur_mask;
    logic [DLY_W-1:0]  cnt;
    logic              q_empty, push, pop, q_clr, load, dec, apply;

    assign {head_value, head_mask, head_delay} = head;

    assign q_empty   = (level == '0);
    assign cmd_ready = !ARESET && (level < LVL_W'(DEPTH)) && !flush && !safe_req
                       && (state != ST_SAFE);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE) || !q_empty;

    dout_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .clr   (q_clr),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_value, cmd_mask, cmd_delay}),
        .rdata (head),
        .level (level)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (safe_req) begin
            state_nxt = ST_SAFE;
        end else if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable && !q_empty)     state_nxt = ST_WAIT;
                ST_WAIT: if (enable && cnt == '0)    state_nxt = ST_IDLE;
                ST_SAFE:                             state_nxt = ST_IDLE;
                default:                             state_nxt = ST_IDLE;
            endcase
        end
    end

    // safe_req outranks flush, which outranks any pop or apply this cycle.
    always_comb begin
        pop   = 1'b0;
        load  = 1'b0;
        dec   = 1'b0;
        apply = 1'b0;
        q_clr = 1'b0;
        if (safe_req || flush) begin
            q_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && !q_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (enable) begin
                        if (cnt == '0) apply = 1'b1;
                        else           dec   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The popped command is latched because the FIFO head moves on at the pop.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            dout      <= SAFE_VAL;
            applied   <= 1'b0;
            cnt       <= '0;
            cur_value <= '0;
            cur_mask  <= '0;
        end else begin
            applied <= apply;
            if (safe_req)   dout <= SAFE_VAL;
            else if (apply) dout <= (dout & ~cur_mask) | (cur_value & cur_mask);
            if (load) begin
                cnt       <= head_delay;
                cur_value <= head_value;
                cur_mask  <= head_mask;
            end else if (dec) begin
                cnt <= cnt - DLY_W'(1);
            end else if (q_clr) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dout_seq_scheduler.sv
// Bench for dout_seq_scheduler: directed scenarios plus a randomized run
// against a timeline model of when each command pops and applies.
module tb_dout_seq_scheduler;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int D    = 4;
    localparam logic [N-1:0] SV = 16'hC3C3;

    typedef struct {
        logic [N-1:0]  value;
        logic [N-1:0]  mask;
        logic [DW-1:0] delay;
    } cmd_t;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, enable, flush, safe_req, applied, busy;
    logic [N-1:0]  cmd_value, cmd_mask, dout;
    logic [DW-1:0] cmd_delay;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    dout_seq_scheduler #(
        .N_CH(N), .DLY_W(DW), .DEPTH(D), .SAFE_VAL(SV)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_value(cmd_value), .cmd_mask(cmd_mask), .cmd_delay(cmd_delay),
        .enable(enable), .flush(flush), .safe_req(safe_req), .dout(dout),
        .applied(applied), .busy(busy), .level(level)
    );

    always #5 ACLK = ~ACLK;

    task tick;
        @(posedge ACLK);
        #1;
    endtask

    task set_cmd(input logic [N-1:0] v, input logic [N-1:0] m, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_value = v;
        cmd_mask  = m;
        cmd_delay = d;
    endtask

    task rst_seq;
        ARESET = 1'b1; cmd_valid = 1'b0; flush = 1'b0; safe_req = 1'b0; enable = 1'b0;
        tick;
        ARESET = 1'b0;
    endtask

    task test_reset;
        ARESET = 1'b1; cmd_valid = 1'b0; flush = 1'b0; safe_req = 1'b0; enable = 1'b1;
        cmd_value = '0; cmd_mask = '0; cmd_delay = '0;
        tick; tick;
        checks++; if (dout !== SV)      begin errors++; $display("FAIL reset_dout got %h exp %h", dout, SV); end
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL reset_applied got %b exp 0", applied); end
        checks++; if (level !== 3'd0)   begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
        ARESET = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b exp 1", cmd_ready); end
    endtask

    task test_latency;
        logic [N-1:0] exp_d;
        rst_seq;
        enable = 1'b1;
        set_cmd(16'h00FF, 16'hFFFF, 16'd5);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", cmd_ready); end
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            exp_d = (k >= 8) ? 16'h00FF : SV;
            checks++; if (dout !== exp_d) begin errors++; $display("FAIL lat_dout t+%0d got %h exp %h", k, dout, exp_d); end
            checks++; if (applied !== (k == 8)) begin errors++; $display("FAIL lat_applied t+%0d got %b exp %b", k, applied, (k == 8)); end
            tick;
        end
    endtask

    task test_enable_hold;
        logic [N-1:0] exp_d;
        int           exp_l;
        rst_seq;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(16'h1111 * (i + 1), 16'hFFFF, 16'd0);
            tick;
        end
        cmd_valid = 1'b0;
        tick; tick;
        #1;
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL hold_level got %0d exp 4", level); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", cmd_ready); end
        checks++; if (dout !== SV)        begin errors++; $display("FAIL hold_dout got %h exp %h", dout, SV); end
        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            exp_d = (k < 2) ? SV : 16'(16'h1111 * ((k > 8 ? 8 : k) / 2));
            exp_l = 4 - (k + 1) / 2;
            if (exp_l < 0) exp_l = 0;
            checks++; if (dout !== exp_d) begin errors++; $display("FAIL drain_dout e+%0d got %h exp %h", k, dout, exp_d); end
            checks++; if (applied !== (k % 2 == 0 && k <= 8)) begin errors++; $display("FAIL drain_applied e+%0d got %b", k, applied); end
            checks++; if (int'(level) != exp_l) begin errors++; $display("FAIL drain_level e+%0d got %0d exp %0d", k, level, exp_l); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got %b exp 0", busy); end
    endtask

    task test_mask;
        rst_seq;
        enable = 1'b1;
        set_cmd(16'h00FF, 16'hFFFF, 16'd0);
        tick; cmd_valid = 1'b0; tick; tick;
        checks++; if (dout !== 16'h00FF) begin errors++; $display("FAIL mask_pre got %h exp 00ff", dout); end
        set_cmd(16'hAB00, 16'hF000, 16'd0);
        tick; cmd_valid = 1'b0; tick; tick;
        checks++; if (dout !== 16'hA0FF) begin errors++; $display("FAIL mask_merge got %h exp a0ff", dout); end
    endtask

    task test_flush;
        rst_seq;
        enable = 1'b1;
        set_cmd(16'h1234, 16'hFFFF, 16'd100);
        tick;
        set_cmd(16'h5678, 16'hFFFF, 16'd0);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) tick;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL flush_pre_level got %0d exp 1", level); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
        flush = 1'b1;
        set_cmd(16'h9999, 16'hFFFF, 16'd0);
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", cmd_ready); end
        tick;
        flush = 1'b0; cmd_valid = 1'b0;
        checks++; if (dout !== SV)       begin errors++; $display("FAIL flush_dout got %h exp %h", dout, SV); end
        checks++; if (level !== 3'd0)    begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        for (int i = 0; i < 5; i++) tick;
        checks++; if (dout !== SV) begin errors++; $display("FAIL flush_later got %h exp %h", dout, SV); end
    endtask

    task test_safe;
        rst_seq;
        enable = 1'b1;
        set_cmd(16'h00FF, 16'hFFFF, 16'd0);
        tick; cmd_valid = 1'b0; tick; tick;
        checks++; if (dout !== 16'h00FF) begin errors++; $display("FAIL safe_pre got %h exp 00ff", dout); end
        enable = 1'b0;
        set_cmd(16'h1111, 16'hFFFF, 16'd0); tick;
        set_cmd(16'h2222, 16'hFFFF, 16'd0); tick;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL safe_q got %0d exp 2", level); end
        safe_req = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL safe_ready got %b exp 0", cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            tick;
            checks++; if (dout !== SV)      begin errors++; $display("FAIL safe_dout %0d got %h exp %h", i, dout, SV); end
            checks++; if (level !== 3'd0)   begin errors++; $display("FAIL safe_level %0d got %0d", i, level); end
            checks++; if (applied !== 1'b0) begin errors++; $display("FAIL safe_applied %0d got %b", i, applied); end
        end
        safe_req = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL safe_exit_ready got %b exp 0", cmd_ready); end
        tick;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL safe_idle_ready got %b exp 1", cmd_ready); end
        set_cmd(16'h1234, 16'hFFFF, 16'd2);
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checks++; if (dout !== ((k >= 5) ? 16'h1234 : SV)) begin errors++; $display("FAIL safe_after t+%0d got %h", k, dout); end
            checks++; if (applied !== (k == 5)) begin errors++; $display("FAIL safe_after_applied t+%0d got %b", k, applied); end
            tick;
        end
    endtask

    task test_pause;
        rst_seq;
        enable = 1'b1;
        set_cmd(16'h5A5A, 16'hFFFF, 16'd20);
        tick;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (k == 10) enable = 1'b0;
            if (k == 20) enable = 1'b1;
            checks++; if (dout !== ((k >= 33) ? 16'h5A5A : SV)) begin errors++; $display("FAIL pause_dout t+%0d got %h", k, dout); end
            checks++; if (applied !== (k == 33)) begin errors++; $display("FAIL pause_applied t+%0d got %b", k, applied); end
            tick;
        end
    endtask

    task test_random;
        cmd_t         q[$];
        cmd_t         c;
        int           idle_at, pend_vis, a;
        logic [N-1:0] mdout, pend_val, exp_d;
        logic         exp_rdy, exp_app;
        rst_seq;
        enable = 1'b1;
        idle_at = 0; pend_vis = -1; mdout = SV; pend_val = SV; exp_d = SV;
        for (int t = 0; t < 400; t++) begin
            exp_app = (t == pend_vis);
            if (exp_app) exp_d = pend_val;
            checks++; if (dout !== exp_d)     begin errors++; $display("FAIL rnd_dout c%0d got %h exp %h", t, dout, exp_d); end
            checks++; if (applied !== exp_app) begin errors++; $display("FAIL rnd_applied c%0d got %b exp %b", t, applied, exp_app); end
            checks++; if (int'(level) != q.size()) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", t, level, q.size()); end
            checks++; if (busy !== (q.size() != 0 || t < idle_at)) begin errors++; $display("FAIL rnd_busy c%0d got %b", t, busy); end
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_value = 16'($urandom);
            cmd_mask  = 16'($urandom);
            cmd_delay = 16'($urandom_range(0, 6));
            #1;
            exp_rdy = (q.size() < D);
            checks++; if (cmd_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", t, cmd_ready, exp_rdy); end
            if (t >= idle_at && q.size() > 0) begin
                c        = q.pop_front();
                a        = t + 1 + int'(c.delay);
                pend_vis = a + 1;
                pend_val = (mdout & ~c.mask) | (c.value & c.mask);
                mdout    = pend_val;
                idle_at  = a + 1;
            end
            if (cmd_valid && exp_rdy) begin
                c.value = cmd_value; c.mask = cmd_mask; c.delay = cmd_delay;
                q.push_back(c);
            end
            tick;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_enable_hold;
        test_mask;
        test_flush;
        test_safe;
        test_pause;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
